complex_word_packer: RTL and testbench



---
 rtl/complex_word_packer.sv | 75 +++++++
 tb/tb_complex_word_packer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/complex_word_packer.sv
// Packs a real sample followed by an imaginary sample into one {real, imag} word.
// Handshakes use valid/ready on both sides. Tag errors cause a realign and are counted.
module complex_word_packer #(
  parameter int WIDTH_IN_WORD = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [(WIDTH_IN_WORD>>1)-1:0] sample_i,
  input  logic                          real_tag_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [WIDTH_IN_WORD-1:0]      RIword_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [ERR_CNT_WIDTH-1:0]      err_cnt_o
);

  localparam int SW = WIDTH_IN_WORD >> 1;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

  typedef enum logic {S_REAL, S_IMAG} state_t;

  state_t        state;
  logic [SW-1:0] real_q;
  logic          acc;
  logic          drn;

  // Valid/ready rule on both sides: a transfer happens on a rising clk_i edge
  // where valid and ready are both high. ready_o never looks at valid_i.
  // A real part can always be taken, because it does not touch the output
  // register. An imaginary part needs the output register free or draining.
  // Reset forces ready_o high so upstream is not blocked while in reset.
  assign ready_o = ~rstn_i | (state == S_REAL) | ~valid_o | ready_i;
  assign acc     = valid_i & ready_o;
  assign drn     = valid_o & ready_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state     <= S_REAL;
      real_q    <= '0;
      RIword_o  <= '0;
      valid_o   <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      // A load later in this block overrides the drain, so there is no bubble.
      if (drn) valid_o <= 1'b0;
      if (acc) begin
        case (state)
          S_REAL: begin
            if (real_tag_i) begin
              real_q <= sample_i;
              state  <= S_IMAG;
            end else if (err_cnt_o != ERR_MAX) begin
              err_cnt_o <= err_cnt_o + ERR_ONE;
            end
          end
          S_IMAG: begin
            if (!real_tag_i) begin
              RIword_o <= {real_q, sample_i};
              valid_o  <= 1'b1;
              state    <= S_REAL;
            end else begin
              real_q <= sample_i;
              if (err_cnt_o != ERR_MAX) err_cnt_o <= err_cnt_o + ERR_ONE;
            end
          end
          default: state <= S_REAL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_complex_word_packer.sv
// Directed bench for complex_word_packer with a queue-based output scoreboard.
// A second instance with a 2-bit error counter covers saturation.
module tb_complex_word_packer;

  localparam int W  = 32;
  localparam int SW = W / 2;

  logic          clk;
  logic          rstn_i;
  logic [SW-1:0] sample_i;
  logic          real_tag_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  RIword_o;
  logic          valid_o;
  logic          ready_i;
  logic [7:0]    err_cnt_o;

  logic          ready2;
  logic [W-1:0]  word2;
  logic          valid2;
  logic [1:0]    err2;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  complex_word_packer #(.WIDTH_IN_WORD(W), .ERR_CNT_WIDTH(8)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .sample_i(sample_i), .real_tag_i(real_tag_i),
    .valid_i(valid_i), .ready_o(ready_o), .RIword_o(RIword_o), .valid_o(valid_o),
    .ready_i(ready_i), .err_cnt_o(err_cnt_o)
  );

  complex_word_packer #(.WIDTH_IN_WORD(W), .ERR_CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .rstn_i(rstn_i), .sample_i(sample_i), .real_tag_i(real_tag_i),
    .valid_i(valid_i), .ready_o(ready2), .RIword_o(word2), .valid_o(valid2),
    .ready_i(ready_i), .err_cnt_o(err2)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a word is consumed at the edge after a negedge with valid_o & ready_i.
  always @(negedge clk) begin
    if (rstn_i && valid_o && ready_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word: got %0h expected none at %0t", RIword_o, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (RIword_o !== e) begin
          bad++;
          $display("FAIL word: got %0h expected %0h at %0t", RIword_o, e, $time);
        end
      end
    end
  end

  // Drivers: inputs change 1 time unit after the rising edge.
  task automatic do_reset();
    @(posedge clk); #1;
    rstn_i  = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("ready_during_reset", 64'(ready_o), 64'd1);
    @(posedge clk);
    @(posedge clk); #1;
    rstn_i = 1'b1;
  endtask

  // Presents a sample and returns 1 unit after the edge that accepted it; valid_i is left high.
  task automatic send(input logic [SW-1:0] s, input logic tag);
    bit done;
    done       = 1'b0;
    sample_i   = s;
    real_tag_i = tag;
    valid_i    = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = ready_o;
      @(posedge clk); #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept expected accept of %0h at %0t", s, $time);
    end
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rstn_i     = 1'b0;
    valid_i    = 1'b0;
    sample_i   = '0;
    real_tag_i = 1'b0;
    ready_i    = 1'b1;

    // Reset state
    do_reset();
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_word", 64'(RIword_o), 64'd0);
    check("rst_err", 64'(err_cnt_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);

    // Basic pair
    exp_q.push_back(32'h1234ABCD);
    send(16'h1234, 1'b1);
    send(16'hABCD, 1'b0);
    valid_i = 1'b0;
    check("pair_valid", 64'(valid_o), 64'd1);
    check("pair_word", 64'(RIword_o), 64'h1234ABCD);
    @(posedge clk); #1;
    check("pair_one_cycle", 64'(valid_o), 64'd0);
    check("pair_err", 64'(err_cnt_o), 64'd0);

    // Backpressure
    ready_i = 1'b0;
    exp_q.push_back(32'hAAAABBBB);
    send(16'hAAAA, 1'b1);
    send(16'hBBBB, 1'b0);
    send(16'h0001, 1'b1);
    sample_i   = 16'h0009;
    real_tag_i = 1'b1;
    valid_i    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready_low", 64'(ready_o), 64'd0);
      @(posedge clk); #1;
    end
    check("bp_hold_word", 64'(RIword_o), 64'hAAAABBBB);
    check("bp_hold_valid", 64'(valid_o), 64'd1);
    check("bp_no_err", 64'(err_cnt_o), 64'd0);
    exp_q.push_back(32'h00010002);
    ready_i = 1'b1;
    send(16'h0002, 1'b0);
    valid_i = 1'b0;
    check("bp_no_bubble", 64'(valid_o), 64'd1);
    check("bp_new_word", 64'(RIword_o), 64'h00010002);
    idle(2);

    // Back-to-back stream
    exp_q.push_back(32'h10002000);
    exp_q.push_back(32'h30004000);
    exp_q.push_back(32'h50006000);
    exp_q.push_back(32'h70008000);
    send(16'h1000, 1'b1); send(16'h2000, 1'b0);
    send(16'h3000, 1'b1); send(16'h4000, 1'b0);
    send(16'h5000, 1'b1); send(16'h6000, 1'b0);
    send(16'h7000, 1'b1); send(16'h8000, 1'b0);
    idle(3);
    check("stream_drained", 64'(exp_q.size()), 64'd0);
    check("stream_err", 64'(err_cnt_o), 64'd0);

    // Tag errors
    send(16'h5555, 1'b0);
    send(16'h1111, 1'b1);
    send(16'h2222, 1'b1);
    exp_q.push_back(32'h22223333);
    send(16'h3333, 1'b0);
    idle(3);
    check("tagerr_cnt", 64'(err_cnt_o), 64'd2);
    check("tagerr_drained", 64'(exp_q.size()), 64'd0);

    // Saturation
    do_reset();
    for (int i = 0; i < 5; i++) send(16'(i + 16'h0F00), 1'b0);
    idle(1);
    check("sat_err2", 64'(err2), 64'd3);
    check("sat_err8", 64'(err_cnt_o), 64'd5);
    send(16'h0F10, 1'b0);
    send(16'h0F11, 1'b0);
    idle(1);
    check("sat_err2_hold", 64'(err2), 64'd3);
    check("sat_err8_more", 64'(err_cnt_o), 64'd7);

    // Reset mid-operation discards pending word and held real
    do_reset();
    ready_i = 1'b0;
    send(16'h1357, 1'b1);
    send(16'h2468, 1'b0);
    send(16'h7777, 1'b1);
    idle(1);
    check("pre_rst_valid", 64'(valid_o), 64'd1);
    do_reset();
    check("post_rst_valid", 64'(valid_o), 64'd0);
    check("post_rst_err", 64'(err_cnt_o), 64'd0);
    check("post_rst_word", 64'(RIword_o), 64'd0);
    ready_i = 1'b1;
    send(16'h8888, 1'b0);
    exp_q.push_back(32'h9999AAAA);
    send(16'h9999, 1'b1);
    send(16'hAAAA, 1'b0);
    idle(3);
    check("post_rst_orphan", 64'(err_cnt_o), 64'd1);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
